// File: rtl/patdet_event_counter_if.sv
// rtl/patdet_event_counter_if.sv - snapshot request/response bundle for the pattern event counter
interface patdet_event_counter_if #(
    parameter int CW = 16,
    parameter int GW = 12
) ();
    logic          snap_req;
    logic          snap_valid;
    logic [CW-1:0] snap_count;
    logic [GW-1:0] snap_last;
    logic [GW-1:0] snap_min;

    // Monitor side: issues requests, receives the statistics snapshot
    modport master (
        output snap_req,
        input  snap_valid,
        input  snap_count,
        input  snap_last,
        input  snap_min
    );

    // Counter side: answers requests with a registered snapshot
    modport slave (
        input  snap_req,
        output snap_valid,
        output snap_count,
        output snap_last,
        output snap_min
    );
endinterface

// File: rtl/patdet_event_counter.sv
// rtl/patdet_event_counter.sv - rising-edge event counter with gap, min-gap and burst statistics
module patdet_event_counter #(
    parameter int CW          = 16,
    parameter int GW          = 12,
    parameter int MIN_SPACING = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det,
    input  logic                     clr,
    patdet_event_counter_if.slave    snap,
    output logic                     event_o,
    output logic                     burst_flag
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [GW-1:0] GAP_MAX = {GW{1'b1}};
    localparam logic [GW-1:0] SPACING = GW'(MIN_SPACING);

    state_t        state;
    state_t        state_n;
    logic          det_q;
    logic          ev;
    logic [CW-1:0] count;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] last_gap;
    logic [GW-1:0] min_gap;

    // A level held for several cycles yields a single event on its rising edge
    assign ev = det & ~det_q;

    // Detector history and registered event pulse; clr does not touch these
    always_ff @(posedge clk) begin
        if (rst) begin
            det_q   <= 1'b0;
            event_o <= 1'b0;
        end else begin
            det_q   <= det;
            event_o <= ev;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: clr overrides any same-cycle event
    always_comb begin
        state_n = state;
        if (clr) begin
            state_n = IDLE;
        end else if (ev) begin
            case (state)
                IDLE:    state_n = FIRST;
                FIRST:   state_n = RUN;
                RUN:     state_n = RUN;
                default: state_n = IDLE;
            endcase
        end
    end

    // Statistics: event count, running gap, last/min gap and sticky burst flag
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count      <= '0;
            gap_cnt    <= '0;
            last_gap   <= '0;
            min_gap    <= GAP_MAX;
            burst_flag <= 1'b0;
        end else if (ev) begin
            gap_cnt <= GW'(1);
            if (state == IDLE) begin
                count <= CW'(1);
            end else begin
                last_gap <= gap_cnt;
                if (gap_cnt < min_gap) begin
                    min_gap <= gap_cnt;
                end
                if (gap_cnt < SPACING) begin
                    burst_flag <= 1'b1;
                end
                if (count != CNT_MAX) begin
                    count <= count + CW'(1);
                end
            end
        end else if (state != IDLE && gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    // Snapshot captures the statistics as they stood before this cycle's update
    always_ff @(posedge clk) begin
        if (rst) begin
            snap.snap_valid <= 1'b0;
            snap.snap_count <= '0;
            snap.snap_last  <= '0;
            snap.snap_min   <= '0;
        end else begin
            snap.snap_valid <= snap.snap_req;
            if (snap.snap_req) begin
                snap.snap_count <= count;
                snap.snap_last  <= last_gap;
                snap.snap_min   <= min_gap;
            end
        end
    end
endmodule
